// File: rtl/agc_gain_update.sv
// agc_gain_update: AGC loop filter, gain += (ref - env) * alpha, clamped, 3-cycle pipeline
// Ports: clk, reset (sync, active-high); i_enable starts/freezes tracking; i_alpha loop step;
// i_reference target level; s_env_data/s_env_valid envelope samples; m_gain_data/m_gain_valid gain
// and update pulse; o_sat last update clamped; o_locked lock flag (only with AGC_LOCK_DET_EN).
module agc_gain_update #(
  parameter int W_REF     = 16,
  parameter int F_REF     = 14,
  parameter int W_ALPHA   = 16,
  parameter int F_ALPHA   = 14,
  parameter int W_GAIN    = 10,
  parameter int F_GAIN    = 6,
  parameter int GAIN_INIT = 64,
  parameter int GAIN_MIN  = 1,
  parameter int GAIN_MAX  = 1023,
  parameter int LOCK_TOL  = 256,
  parameter int LOCK_CNT  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_enable,
  input  logic [W_ALPHA-1:0] i_alpha,
  input  logic [W_REF-1:0]   i_reference,
  input  logic [W_REF-1:0]   s_env_data,
  input  logic               s_env_valid,
  output logic [W_GAIN-1:0]  m_gain_data,
  output logic               m_gain_valid,
  output logic               o_sat,
  output logic               o_locked
);
  localparam int WE = W_REF + 1;
  localparam int WP = W_REF + 1 + W_ALPHA;
  localparam int SH = F_REF + F_ALPHA - F_GAIN;
  localparam int WS = (WP > W_GAIN ? WP : W_GAIN) + 1;
  localparam logic signed [WS-1:0] MIN_S = WS'(GAIN_MIN);
  localparam logic signed [WS-1:0] MAX_S = WS'(GAIN_MAX);
  typedef enum logic [1:0] {IDLE, TRACK, FREEZE} state_t;
  state_t state, state_nxt;
  logic accept, v1, v2, sat_nxt;
  logic signed [WE-1:0] err_c, err_r;
  logic signed [WP-1:0] err_x, alpha_x, prod_r, delta;
  logic signed [WS-1:0] sum;
  logic [W_GAIN-1:0] gain_nxt;
  always_comb begin
    state_nxt = state == TRACK ? (i_enable ? TRACK : FREEZE) : (i_enable ? TRACK : state);
    accept = s_env_valid && state == TRACK;
    err_c = $signed({1'b0, i_reference}) - $signed({1'b0, s_env_data});
    err_x = {{W_ALPHA{err_r[WE-1]}}, err_r};
    alpha_x = {{WE{1'b0}}, i_alpha};
    delta = prod_r >>> SH;
    // full-width sum so clamping sees the true result before truncation
    sum = {{(WS-WP){delta[WP-1]}}, delta} + {{(WS-W_GAIN){1'b0}}, m_gain_data};
    sat_nxt = sum < MIN_S || sum > MAX_S;
    gain_nxt = sum < MIN_S ? W_GAIN'(GAIN_MIN) : sum > MAX_S ? W_GAIN'(GAIN_MAX) : sum[W_GAIN-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      v1 <= 1'b0;
      v2 <= 1'b0;
      m_gain_valid <= 1'b0;
      o_sat <= 1'b0;
      m_gain_data <= W_GAIN'(GAIN_INIT);
    end else begin
      state <= state_nxt;
      v1 <= accept;
      v2 <= v1;
      m_gain_valid <= v2;
      if (v2) begin
        m_gain_data <= gain_nxt;
        o_sat <= sat_nxt;
      end
    end
  end
  always_ff @(posedge clk) begin
    err_r <= err_c;
    prod_r <= err_x * alpha_x;
  end
`ifdef AGC_LOCK_DET_EN
  localparam int WC = $clog2(LOCK_CNT + 1);
  logic [WC-1:0] cnt;
  logic [WE-1:0] err_abs;
  assign err_abs = err_c[WE-1] ? -err_c : err_c;
  // counter only moves on accepted samples, so it naturally holds in FREEZE
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      o_locked <= 1'b0;
    end else begin
      if (accept) cnt <= err_abs <= WE'(LOCK_TOL) ? (cnt == WC'(LOCK_CNT) ? cnt : cnt + 1'b1) : '0;
      o_locked <= cnt == WC'(LOCK_CNT);
    end
  end
`else
  assign o_locked = 1'b0;
`endif
endmodule

// File: tb/tb_agc_gain_update.sv
// tb_agc_gain_update: self-checking bench for agc_gain_update (directed cases plus random vs model)
module tb_agc_gain_update;
  logic clk = 0, reset = 1, i_enable = 0, s_env_valid = 0;
  logic [15:0] i_alpha = 0, i_reference = 0, s_env_data = 0;
  logic [9:0] m_gain_data;
  logic m_gain_valid, o_sat, o_locked;
  int n_cmp = 0, n_bad = 0;

  agc_gain_update dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_alpha(i_alpha),
    .i_reference(i_reference), .s_env_data(s_env_data), .s_env_valid(s_env_valid),
    .m_gain_data(m_gain_data), .m_gain_valid(m_gain_valid), .o_sat(o_sat), .o_locked(o_locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint p, input longint d);
    return p < 0 ? -((-p + d - 1) / d) : p / d;
  endfunction

  // reference model: a sample is tracked iff i_enable was high at the previous edge (not reset);
  // err taken at acceptance, multiplied by the alpha present one cycle later, applied one cycle after that
  bit trk, seen, e_v, p_v, m_val, m_sat, m_lock, acc;
  longint m_gain, e_err, p_prod, err_now, s;
  int m_cnt;
  always @(posedge clk) begin
    if (reset) begin
      trk = 0; e_v = 0; p_v = 0; m_val = 0; m_sat = 0; m_lock = 0; m_cnt = 0; m_gain = 64; seen = 1;
    end else begin
      acc = s_env_valid && trk;
      err_now = longint'(i_reference) - longint'(s_env_data);
      m_val = p_v;
      if (p_v) begin
        s = m_gain + floor_div(p_prod, 64'd4194304);
        m_sat = s < 1 || s > 1023;
        m_gain = s < 1 ? 1 : (s > 1023 ? 1023 : s);
      end
      p_v = e_v;
      p_prod = e_err * longint'(i_alpha);
`ifdef AGC_LOCK_DET_EN
      m_lock = m_cnt == 16;
      if (acc) m_cnt = ((err_now < 0 ? -err_now : err_now) <= 256) ? (m_cnt < 16 ? m_cnt + 1 : 16) : 0;
`endif
      e_v = acc;
      e_err = err_now;
      trk = i_enable;
    end
    #1;
    if (seen) begin
      chk("model_gain", 32'(m_gain_data), 32'(m_gain));
      chk("model_valid", 32'(m_gain_valid), 32'(m_val));
      chk("model_sat", 32'(o_sat), 32'(m_sat));
      chk("model_locked", 32'(o_locked), 32'(m_lock));
    end
  end

  task automatic cyc(input bit r, input bit en, input bit v, input logic [15:0] env);
    reset = r; i_enable = en; s_env_valid = v; s_env_data = env;
    @(negedge clk);
  endtask

  initial begin
    int upd [4] = '{319, 574, 829, 1023};
    int pulses;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset_gain", 32'(m_gain_data), 64);
    chk("reset_valid", 32'(m_gain_valid), 0);
    chk("reset_sat", 32'(o_sat), 0);
    chk("reset_locked", 32'(o_locked), 0);
    // single step
    i_reference = 8192; i_alpha = 16384;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 4096);
    chk("step_valid_n1", 32'(m_gain_valid), 0);
    cyc(0, 1, 0, 0);
    chk("step_valid_n2", 32'(m_gain_valid), 0);
    cyc(0, 1, 0, 0);
    chk("step_valid_n3", 32'(m_gain_valid), 1);
    chk("step_gain", 32'(m_gain_data), 80);
    cyc(0, 1, 0, 0);
    chk("step_valid_after", 32'(m_gain_valid), 0);
    chk("step_gain_hold", 32'(m_gain_data), 80);
    // upper clamp
    cyc(1, 0, 0, 0);
    i_reference = 16383; i_alpha = 65535;
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, k < 4, 0);
      if (k >= 2) begin
        chk("up_gain", 32'(m_gain_data), 32'(upd[k-2]));
        chk("up_sat", 32'(o_sat), 32'(k == 5));
        chk("up_valid", 32'(m_gain_valid), 1);
      end
    end
    // lower clamp
    cyc(1, 0, 0, 0);
    i_reference = 0; i_alpha = 65535;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 16383);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("low_gain", 32'(m_gain_data), 1);
    chk("low_sat", 32'(o_sat), 1);
    chk("low_valid", 32'(m_gain_valid), 1);
`ifdef AGC_LOCK_DET_EN
    cyc(1, 0, 0, 0);
    i_reference = 8192; i_alpha = 0;
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 16; k++) cyc(0, 1, 1, 8192);
    chk("lock_not_yet", 32'(o_locked), 0);
    cyc(0, 1, 0, 0);
    chk("lock_set", 32'(o_locked), 1);
    cyc(0, 1, 1, 8492);
    chk("lock_still", 32'(o_locked), 1);
    cyc(0, 1, 0, 0);
    chk("lock_clear", 32'(o_locked), 0);
`endif
    // freeze with two samples in flight
    cyc(1, 0, 0, 0);
    i_reference = 8192; i_alpha = 16384;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 4096);
    cyc(0, 0, 1, 4096);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 1, 4096);
      pulses += int'(m_gain_valid);
    end
    chk("frz_pulses", 32'(pulses), 2);
    chk("frz_gain", 32'(m_gain_data), 96);
    cyc(0, 1, 1, 4096);
    cyc(0, 1, 1, 4096);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("frz_resume_gain", 32'(m_gain_data), 112);
    chk("frz_resume_valid", 32'(m_gain_valid), 1);
    // reset one cycle after acceptance
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 4096);
    cyc(1, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 0);
      chk("rmid_valid", 32'(m_gain_valid), 0);
      chk("rmid_gain", 32'(m_gain_data), 64);
      chk("rmid_locked", 32'(o_locked), 0);
    end
    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      int t;
      if ($urandom_range(0, 19) == 0) i_reference = 16'($urandom_range(0, 16383));
      if ($urandom_range(0, 9) == 0) i_alpha = 16'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 4096));
      t = $urandom_range(0, 1) == 0 ? int'(i_reference) + int'($urandom_range(0, 600)) - 300 : int'($urandom_range(0, 65535));
      t = t < 0 ? 0 : (t > 65535 ? 65535 : t);
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, 16'(t));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/agc_gain_update.md
AGC_GAIN_UPDATE -- requirements
Module: agc_gain_update

Interface
REQ-001 The block SHALL have parameter W_REF, default 16, meaning reference/envelope width (unsigned).
REQ-002 The block SHALL have parameter F_REF, default 14, meaning fractional bits of reference/envelope.
REQ-003 The block SHALL have parameter W_ALPHA, default 16, meaning loop step width (unsigned).
REQ-004 The block SHALL have parameter F_ALPHA, default 14, meaning fractional bits of loop step.
REQ-005 The block SHALL have parameter W_GAIN, default 10, meaning gain width (unsigned).
REQ-006 The block SHALL have parameter F_GAIN, default 6, meaning fractional bits of gain.
REQ-007 The block SHALL have parameters GAIN_INIT=64, GAIN_MIN=1, GAIN_MAX=1023, meaning reset gain and clamp limits.
REQ-008 The block SHALL have parameters LOCK_TOL=256 (|error| tolerance, envelope LSBs) and LOCK_CNT=16 (consecutive in-tolerance samples for lock).
REQ-009 The block SHALL have port clk, input, 1, the single clock.
REQ-010 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-011 The block SHALL have port i_enable, input, 1, which enables loop tracking.
REQ-012 The block SHALL have port i_alpha, input, W_ALPHA, the loop step.
REQ-013 The block SHALL have port i_reference, input, W_REF, the target envelope level.
REQ-014 The block SHALL have port s_env_data, input, W_REF, the filtered magnitude envelope from the EMA stage.
REQ-015 The block SHALL have port s_env_valid, input, 1, the envelope valid strobe.
REQ-016 The block SHALL have port m_gain_data, output, W_GAIN, the current gain, driving the multiplier in the AGC stage.
REQ-017 The block SHALL have port m_gain_valid, output, 1, a one-cycle pulse on each gain update.
REQ-018 The block SHALL have port o_sat, output, 1, asserted when the last update was clamped.
REQ-019 The block SHALL have port o_locked, output, 1, the lock indicator.

Function
REQ-020 The FSM SHALL have states IDLE, TRACK and FREEZE; IDLE->TRACK when i_enable=1; TRACK->FREEZE when i_enable=0; FREEZE->TRACK when i_enable=1; IDLE is entered only via reset.
REQ-021 A sample SHALL be accepted when s_env_valid=1 and the state is TRACK in that cycle; other samples are dropped, with no backpressure.
REQ-022 Stage 1 SHALL register err = i_reference - s_env_data as signed W_REF+1 bits.
REQ-023 Stage 2 SHALL register prod = err * i_alpha, signed W_REF+1+W_ALPHA bits, exact.
REQ-024 Stage 3 SHALL compute delta = prod arithmetically shifted right by F_REF+F_ALPHA-F_GAIN (floor), and next = gain + delta in full width, clamped to [GAIN_MIN, GAIN_MAX], then register it.
REQ-025 Latency SHALL be 3 cycles: a sample accepted at cycle N gives a new m_gain_data with m_gain_valid=1 at N+3.
REQ-026 Throughput SHALL be one sample per cycle; each stage-3 update SHALL use the gain register value of that cycle.
REQ-027 o_sat SHALL update only on an update cycle: 1 if clamped, else 0.
REQ-028 Samples already in the pipeline when FREEZE is entered SHALL complete and update the gain; afterwards the gain SHALL hold.
REQ-029 m_gain_data SHALL always reflect the gain register, including in IDLE and FREEZE.

Reset
REQ-030 Synchronous reset SHALL set: state=IDLE, gain=GAIN_INIT, pipeline valids=0, m_gain_valid=0, o_sat=0, o_locked=0, lock counter=0.
REQ-031 Reset asserted mid-pipeline SHALL discard all in-flight samples; no m_gain_valid pulse follows it.

Configuration
REQ-032 Macro AGC_LOCK_DET_EN defined: a counter SHALL increment, saturating at LOCK_CNT, for each stage-1 err with |err|<=LOCK_TOL; it SHALL clear on err with |err|>LOCK_TOL.
REQ-033 With AGC_LOCK_DET_EN, o_locked SHALL be registered as (counter==LOCK_CNT), one cycle after the deciding err is registered; the counter SHALL hold in FREEZE.
REQ-034 Without AGC_LOCK_DET_EN, o_locked SHALL be constant 0 and no counter logic SHALL exist.

Verification (defaults, gain 64 = 1.0)
REQ-035 The bench SHALL check step: ref=8192, alpha=16384, env=4096 single sample -> err=4096, delta=16, m_gain_data 64->80 with m_gain_valid exactly 3 cycles later.
REQ-036 The bench SHALL check upper clamp: ref=16383, alpha=65535, env=0 each cycle -> gains 319, 574, 829, then 1023 with o_sat=1 on the 4th update.
REQ-037 The bench SHALL check lower clamp: ref=0, alpha=65535, env=16383 -> delta=-256, gain 64->1, o_sat=1.
REQ-038 The bench SHALL check lock (macro on): env=ref for 16 samples -> o_locked=1 one cycle after the 16th err; then env=ref+300 -> o_locked=0 one cycle after that err.
REQ-039 The bench SHALL check freeze: drop i_enable with 2 samples in flight -> 2 updates occur, then gain holds while valid samples are ignored; re-raise i_enable -> tracking resumes.
REQ-040 The bench SHALL check reset mid-pipeline: reset one cycle after acceptance -> gain=64, no m_gain_valid pulse, o_locked=0.
